// File: rtl/uart_tx_sched_if.sv
// CSR write-port bundle feeding the UART transmit scheduler.
//   csr_we    : write strobe
//   csr_addr  : 12-bit CSR address
//   csr_wdata : 32-bit write data
// master drives the bus (core / testbench), slave receives it (uart_tx_sched).
interface uart_tx_sched_if;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;

  modport master (output csr_we, csr_addr, csr_wdata);
  modport slave  (input  csr_we, csr_addr, csr_wdata);
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: buffers byte/word CSR pushes in a circular byte
// queue and serialises them as 8N1 frames at CmpVal clocks per bit.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   csr          : CSR write bundle (slave modport)
//   tx           : registered serial output, idles high
//   level        : bytes currently buffered (0..QueueSize)
//   empty, full  : level == 0 / level == QueueSize
//   busy         : frame in flight or data buffered
//   drop         : combinational pulse when a push is rejected
module uart_tx_sched #(
  parameter int unsigned QueueSize = 256,
  parameter int unsigned CmpVal    = 173,
  parameter logic [11:0] WordAddr  = 12'h050,
  parameter logic [11:0] ByteAddr  = 12'h051
) (
  input  logic                       clk,
  input  logic                       reset_n,
  uart_tx_sched_if.slave             csr,
  output logic                       tx,
  output logic [$clog2(QueueSize):0] level,
  output logic                       empty,
  output logic                       full,
  output logic                       busy,
  output logic                       drop
);

  localparam int unsigned PW = $clog2(QueueSize);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = $clog2(CmpVal);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT          state, stateNext;
  logic [7:0]     mem [QueueSize];
  logic [PW-1:0]  wrPtr, rdPtr;
  logic [CW-1:0]  cnt, cntNext;
  logic [2:0]     bitIdx, bitNext;
  logic [7:0]     shiftReg, shiftNext;
  logic           txNext, pop, bitEnd;
  logic           wordReq, byteReq, wordOk, byteOk;
  logic [LW-1:0]  freeSpace;
  logic [2:0]     pushCnt;

  // Free space uses the pre-pop level, so a same-cycle pop never helps a push.
  assign freeSpace = LW'(QueueSize) - level;
  assign wordReq   = csr.csr_we && (csr.csr_addr == WordAddr);
  assign byteReq   = csr.csr_we && (csr.csr_addr == ByteAddr);
  assign wordOk    = wordReq && (freeSpace >= LW'(4));
  assign byteOk    = byteReq && (freeSpace != '0);
  assign pushCnt   = wordOk ? 3'd4 : (byteOk ? 3'd1 : 3'd0);
  assign drop      = (wordReq && !wordOk) || (byteReq && !byteOk);

  assign empty = (level == '0);
  assign full  = (level == LW'(QueueSize));
  assign busy  = (state != IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (wordOk) begin
      for (int unsigned i = 0; i < 4; i++) begin
        mem[wrPtr + PW'(i)] <= csr.csr_wdata[8*i +: 8];
      end
    end else if (byteOk) begin
      mem[wrPtr] <= csr.csr_wdata[7:0];
    end
  end

  // tx is registered from the next-state decode so that the start bit
  // appears in the same cycle the FSM enters START.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txNext    = tx;
    pop       = 1'b0;
    bitEnd    = (cnt == CW'(CmpVal - 1));
    unique case (state)
      IDLE: begin
        cntNext = '0;
        txNext  = 1'b1;
        if (level != '0) begin
          pop       = 1'b1;
          shiftNext = mem[rdPtr];
          stateNext = START;
          txNext    = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          cntNext   = '0;
          bitNext   = '0;
          stateNext = DATA;
          txNext    = shiftReg[0];
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          cntNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitNext   = bitIdx + 3'd1;
            shiftNext = {1'b0, shiftReg[7:1]};
            txNext    = shiftReg[1];
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      STOP: begin
        if (bitEnd) begin
          cntNext = '0;
          if (level != '0) begin
            pop       = 1'b1;
            shiftNext = mem[rdPtr];
            stateNext = START;
            txNext    = 1'b0;
          end else begin
            stateNext = IDLE;
            txNext    = 1'b1;
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      tx       <= txNext;
      wrPtr    <= wrPtr + PW'(pushCnt);
      rdPtr    <= rdPtr + PW'(pop);
      level    <= level + LW'(pushCnt) - LW'(pop);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  localparam int CMP = 8;
  localparam int FR  = 10 * CMP;
  localparam logic [11:0] WA = 12'h050;
  localparam logic [11:0] BA = 12'h051;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx, empty, full, busy, drop;
  logic [8:0] level;
  int         cyc = 0;
  int         nCompared = 0;
  int         nMismatch = 0;

  typedef struct {
    logic [7:0] data;
    int         startCyc;
    logic       stopOk;
  } rxT;

  logic [7:0] expQ[$];
  rxT         rxQ[$];
  rxT         monR;

  uart_tx_sched_if busIf ();

  uart_tx_sched #(.QueueSize(256), .CmpVal(CMP), .WordAddr(WA), .ByteAddr(BA)) dut (
    .clk(clk), .reset_n(reset_n), .csr(busIf), .tx(tx), .level(level),
    .empty(empty), .full(full), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples each bit mid-period and records frame start cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        monR.startCyc = cyc;
        monR.data = '0;
        repeat (CMP / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (CMP) @(negedge clk);
          monR.data[b] = tx;
        end
        repeat (CMP) @(negedge clk);
        monR.stopOk = (tx === 1'b1);
        rxQ.push_back(monR);
      end
    end
  end

  task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data,
                          output logic dropSeen, output logic [8:0] lvlSeen,
                          output logic fullSeen, output int wrCyc);
    busIf.csr_we = 1'b1;
    busIf.csr_addr = addr;
    busIf.csr_wdata = data;
    wrCyc = cyc;
    @(negedge clk);
    dropSeen = drop;
    lvlSeen = level;
    fullSeen = full;
    @(posedge clk);
    #1;
    busIf.csr_we = 1'b0;
  endtask

  task automatic test_reset();
    busIf.csr_we = 1'b0;
    busIf.csr_addr = '0;
    busIf.csr_wdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nCompared++; if (tx !== 1'b1) begin nMismatch++; $display("FAIL reset_tx got %b exp 1", tx); end
    nCompared++; if (level !== 9'd0) begin nMismatch++; $display("FAIL reset_level got %0d exp 0", level); end
    nCompared++; if (empty !== 1'b1) begin nMismatch++; $display("FAIL reset_empty got %b exp 1", empty); end
    nCompared++; if (full !== 1'b0) begin nMismatch++; $display("FAIL reset_full got %b exp 0", full); end
    nCompared++; if (busy !== 1'b0) begin nMismatch++; $display("FAIL reset_busy got %b exp 0", busy); end
    nCompared++; if (drop !== 1'b0) begin nMismatch++; $display("FAIL reset_drop got %b exp 0", drop); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_addr();
    logic d, f; logic [8:0] l; int wc, bad;
    csrWrite(12'h052, 32'h0000_00FF, d, l, f, wc);
    nCompared++; if (d !== 1'b0) begin nMismatch++; $display("FAIL badaddr_drop got %b exp 0", d); end
    @(negedge clk);
    nCompared++; if (level !== 9'd0) begin nMismatch++; $display("FAIL badaddr_level got %0d exp 0", level); end
    bad = 0;
    repeat (2 * FR) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    nCompared++; if (bad !== 0) begin nMismatch++; $display("FAIL badaddr_idle got %0d active cycles exp 0", bad); end
    nCompared++; if (rxQ.size() !== 0) begin nMismatch++; $display("FAIL badaddr_frames got %0d exp 0", rxQ.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_byte();
    logic d, f; logic [8:0] l; int n, fallCyc; rxT r;
    csrWrite(BA, 32'h0000_0055, d, l, f, n);
    expQ.push_back(8'h55);
    nCompared++; if (d !== 1'b0) begin nMismatch++; $display("FAIL single_drop got %b exp 0", d); end
    @(negedge clk);
    nCompared++; if (level !== 9'd1) begin nMismatch++; $display("FAIL single_level got %0d exp 1", level); end
    nCompared++; if (empty !== 1'b0) begin nMismatch++; $display("FAIL single_empty got %b exp 0", empty); end
    nCompared++; if (busy !== 1'b1) begin nMismatch++; $display("FAIL single_busy got %b exp 1", busy); end
    fallCyc = -1;
    for (int k = 0; k < 3 * FR; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin fallCyc = cyc; break; end
    end
    nCompared++; if (fallCyc !== n + 2 + FR) begin nMismatch++; $display("FAIL single_busyfall got %0d exp %0d", fallCyc, n + 2 + FR); end
    nCompared++; if (rxQ.size() !== 1) begin nMismatch++; $display("FAIL single_frames got %0d exp 1", rxQ.size()); end
    if (rxQ.size() > 0 && expQ.size() > 0) begin
      r = rxQ.pop_front();
      nCompared++; if (r.data !== expQ[0]) begin nMismatch++; $display("FAIL single_data got %h exp %h", r.data, expQ[0]); end
      nCompared++; if (r.startCyc !== n + 2) begin nMismatch++; $display("FAIL single_start got %0d exp %0d", r.startCyc, n + 2); end
      nCompared++; if (r.stopOk !== 1'b1) begin nMismatch++; $display("FAIL single_stop got %b exp 1", r.stopOk); end
      void'(expQ.pop_front());
    end
    rxQ.delete(); expQ.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_word_order();
    logic d, f; logic [8:0] l; int n, fallCyc; rxT r; logic [7:0] e;
    csrWrite(WA, 32'h4433_2211, d, l, f, n);
    for (int k = 0; k < 4; k++) expQ.push_back(8'(8'h11 * (k + 1)));
    nCompared++; if (d !== 1'b0) begin nMismatch++; $display("FAIL word_drop got %b exp 0", d); end
    fallCyc = -1;
    for (int k = 0; k < 6 * FR; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin fallCyc = cyc; break; end
    end
    nCompared++; if (fallCyc !== n + 2 + 4 * FR) begin nMismatch++; $display("FAIL word_busyfall got %0d exp %0d", fallCyc, n + 2 + 4 * FR); end
    nCompared++; if (rxQ.size() !== 4) begin nMismatch++; $display("FAIL word_frames got %0d exp 4", rxQ.size()); end
    for (int i = 0; i < 4; i++) begin
      if (rxQ.size() == 0 || expQ.size() == 0) break;
      r = rxQ.pop_front(); e = expQ.pop_front();
      nCompared++; if (r.data !== e) begin nMismatch++; $display("FAIL word_data[%0d] got %h exp %h", i, r.data, e); end
      nCompared++; if (r.startCyc !== n + 2 + i * FR) begin nMismatch++; $display("FAIL word_start[%0d] got %0d exp %0d", i, r.startCyc, n + 2 + i * FR); end
      nCompared++; if (r.stopOk !== 1'b1) begin nMismatch++; $display("FAIL word_stop[%0d] got %b exp 1", i, r.stopOk); end
    end
    rxQ.delete(); expQ.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    logic d, f; logic [8:0] l; int n, wc, bad;
    csrWrite(BA, 32'h0000_00A5, d, l, f, n);
    csrWrite(WA, 32'h0102_0304, d, l, f, wc);
    while (cyc < n + 2 + 4 * CMP + 2) @(negedge clk);
    // bit 3 of 0xA5 is 0, so the line must be low just before reset
    nCompared++; if (tx !== 1'b0) begin nMismatch++; $display("FAIL midrst_bit3 got %b exp 0", tx); end
    nCompared++; if (level !== 9'd4) begin nMismatch++; $display("FAIL midrst_prelevel got %0d exp 4", level); end
    #1 reset_n = 1'b0;
    #1;
    nCompared++; if (tx !== 1'b1) begin nMismatch++; $display("FAIL midrst_tx got %b exp 1", tx); end
    nCompared++; if (level !== 9'd0) begin nMismatch++; $display("FAIL midrst_level got %0d exp 0", level); end
    nCompared++; if (busy !== 1'b0) begin nMismatch++; $display("FAIL midrst_busy got %b exp 0", busy); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (FR + 2 * CMP) @(negedge clk);
    rxQ.delete();
    bad = 0;
    repeat (3 * FR) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    nCompared++; if (bad !== 0) begin nMismatch++; $display("FAIL midrst_idle got %0d low cycles exp 0", bad); end
    nCompared++; if (rxQ.size() !== 0) begin nMismatch++; $display("FAIL midrst_frames got %0d exp 0", rxQ.size()); end
    nCompared++; if (empty !== 1'b1) begin nMismatch++; $display("FAIL midrst_empty got %b exp 1", empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_drop();
    logic d, f; logic [8:0] l; int n, wc, fallCyc, dropErr; rxT r; logic [7:0] e;
    dropErr = 0;
    for (int i = 0; i < 64; i++) begin
      csrWrite(WA, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, d, l, f, wc);
      if (i == 0) n = wc;
      for (int k = 0; k < 4; k++) expQ.push_back(8'(4*i+k));
      if (d !== 1'b0) dropErr++;
    end
    nCompared++; if (dropErr !== 0) begin nMismatch++; $display("FAIL full_worddrops got %0d exp 0", dropErr); end
    csrWrite(WA, 32'hDEAD_BEEF, d, l, f, wc);
    nCompared++; if (d !== 1'b1) begin nMismatch++; $display("FAIL full_word64_drop got %b exp 1", d); end
    nCompared++; if (l !== 9'd255) begin nMismatch++; $display("FAIL full_level63 got %0d exp 255", l); end
    csrWrite(BA, 32'h0000_00AA, d, l, f, wc);
    expQ.push_back(8'hAA);
    nCompared++; if (d !== 1'b0) begin nMismatch++; $display("FAIL full_byte65_drop got %b exp 0", d); end
    nCompared++; if (l !== 9'd255) begin nMismatch++; $display("FAIL full_level64 got %0d exp 255", l); end
    csrWrite(BA, 32'h0000_00BB, d, l, f, wc);
    nCompared++; if (d !== 1'b1) begin nMismatch++; $display("FAIL full_byte66_drop got %b exp 1", d); end
    nCompared++; if (l !== 9'd256) begin nMismatch++; $display("FAIL full_level65 got %0d exp 256", l); end
    nCompared++; if (f !== 1'b1) begin nMismatch++; $display("FAIL full_flag got %b exp 1", f); end
    @(negedge clk);
    nCompared++; if (level !== 9'd256) begin nMismatch++; $display("FAIL full_level66 got %0d exp 256", level); end
    fallCyc = -1;
    for (int k = 0; k < 270 * FR; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin fallCyc = cyc; break; end
    end
    nCompared++; if (fallCyc !== n + 2 + 257 * FR) begin nMismatch++; $display("FAIL full_busyfall got %0d exp %0d", fallCyc, n + 2 + 257 * FR); end
    nCompared++; if (rxQ.size() !== 257) begin nMismatch++; $display("FAIL full_frames got %0d exp 257", rxQ.size()); end
    for (int i = 0; i < 257; i++) begin
      if (rxQ.size() == 0 || expQ.size() == 0) break;
      r = rxQ.pop_front(); e = expQ.pop_front();
      nCompared++; if (r.data !== e || r.stopOk !== 1'b1) begin nMismatch++; $display("FAIL full_data[%0d] got %h/stop %b exp %h/stop 1", i, r.data, r.stopOk, e); end
      nCompared++; if (r.startCyc !== n + 2 + i * FR) begin nMismatch++; $display("FAIL full_start[%0d] got %0d exp %0d", i, r.startCyc, n + 2 + i * FR); end
    end
    rxQ.delete(); expQ.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_bad_addr();
    test_single_byte();
    test_word_order();
    test_reset_midframe();
    test_full_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller for the UART peripheral. It accepts byte and word pushes from the CSR write path into a 256-byte circular buffer, and schedules bytes out of that buffer to an 8N1 serialiser at the configured baud rate. It sits between the core's CSR write port and the `tx` pin, and owns the FIFO pointers, the fill level, the baud counter and the frame state machine.

## Interface
Parameters:
- `QueueSize`, default 256: buffer depth in bytes; must be a power of two.
- `CmpVal`, default 173 (20 MHz / 115200): clock cycles per serial bit; must be ≥ 2.
- `WordAddr`, default 'h50: CSR address for a 4-byte push.
- `ByteAddr`, default 'h51: CSR address for a 1-byte push.

Ports:
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `csr_we`, in, 1: CSR write strobe.
- `csr_addr`, in, 12: CSR address.
- `csr_wdata`, in, 32: CSR write data.
- `tx`, out, 1: serial line; idles high.
- `level`, out, $clog2(QueueSize)+1: bytes currently buffered.
- `empty`, out, 1: `level` == 0.
- `full`, out, 1: `level` == QueueSize.
- `busy`, out, 1: a frame is in flight or `level` != 0.
- `drop`, out, 1: one-cycle pulse when a push is rejected.

## Operation
- **Reset values:** `tx`=1, `level`=0, `empty`=1, `full`=0, `busy`=0, `drop`=0. Read/write pointers are 0, the FSM is IDLE and the baud counter is 0.
- **Word push:** `csr_we` with `csr_addr`==WordAddr. The push is accepted only if free ≥ 4, where free = QueueSize − `level` in the current cycle.
  - On acceptance, bytes `csr_wdata[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` are written in that order.
  - Otherwise the whole word is discarded, `drop`=1 for that cycle, and nothing changes.
- **Byte push:** `csr_addr`==ByteAddr pushes `csr_wdata[7:0]` if free ≥ 1; otherwise it is dropped and `drop` pulses.
- **Other addresses:** writes to any other address are ignored, with no `drop`.
- **Pointers:** both are $clog2(QueueSize) bits and wrap modulo QueueSize. `level` is tracked as a separate counter (0..QueueSize).
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE with `level`>0: pop the byte at the read pointer into the shift register and go to START.
  - START drives `tx`=0 for CmpVal cycles, then goes to DATA.
  - DATA drives 8 bits LSB first, each held for CmpVal cycles, counted by a 3-bit index; then goes to STOP.
  - STOP drives `tx`=1 for CmpVal cycles. At its end, if `level`>0 it pops the next byte and goes directly to START with no idle gap; otherwise it goes to IDLE.
- **Baud counter:** counts 0..CmpVal−1, resets to 0 on every state or bit change, and is held at 0 in IDLE.
- **`tx` output:** registered, driven from the FSM state and the shift register.
- **Simultaneous push and pop:** `level` next = `level` + pushed − popped. The free check uses the pre-pop `level`, which is deliberately conservative.
- **Reset mid-frame:** `reset_n` low aborts the frame immediately, forces `tx`=1 asynchronously and discards buffered data.

## Timing
- A push presented in cycle N is reflected in `level`, `empty` and `full` in cycle N+1.
- With the FIFO previously empty and the FSM in IDLE, a push in cycle N gives a pop at the end of N+1 and `tx`=0 from cycle N+2.
- A frame lasts exactly 10·CmpVal cycles. Back-to-back frames have a start-to-start period of 10·CmpVal.
- `busy` falls in the cycle after STOP completes with `level`==0.
- `drop` is asserted combinationally in the same cycle as the rejected write.

## Test plan
- **Reset:** hold `reset_n`=0 → `tx`=1, `level`=0, `empty`=1, `full`=0, `busy`=0, `drop`=0.
- **Single byte:** byte write 0x55 in cycle N → `tx` low from N+2 for 173 cycles; then data bits 1,0,1,0,1,0,1,0, each 173 cycles; then stop high for 173 cycles. `busy` drops after 1730 cycles of frame.
- **Word ordering:** word write 0x44332211 → frames 0x11, 0x22, 0x33, 0x44 back-to-back, total 6920 cycles, with no idle high gap between a stop bit and the next start bit.
- **Full and drop:**
  - Word writes in cycles 0..63 → `level`=255 after cycle 63.
  - Word write in cycle 64 → `drop`=1, `level` stays 255.
  - Byte write in cycle 65 → `level`=256, `full`=1.
  - Byte write in cycle 66 → `drop`=1.
  - Afterwards all 256 bytes are transmitted in order, including across pointer wrap-around.
- **Reset mid-frame:** pull `reset_n` low during data bit 3 of a frame → `tx`=1 within the same cycle and `level`=0. After release, the line stays idle high and no residual frame is sent.
- **Bad address:** a write to 'h52 → no change to `level`, `drop`=0, `tx` stays idle.
